// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller and its countdown display driver.
package traffic_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        MAJ_G = 2'd0,
        MAJ_Y = 2'd1,
        MIN_G = 2'd2,
        MIN_Y = 2'd3
    } phase_e;

    // Lamp bits are {red, yellow, green}
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Loadable seconds down-counter for the current phase; load wins over decrement.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= RST_VAL;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= cnt - CNT_W'(1);
    end

    assign expire = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/traffic_fsm.sv
// Major/minor intersection controller: four-phase lamp sequence, seconds timer, registered countdowns.
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int T_MAJOR_GREEN = 40,
    parameter int T_MINOR_GREEN = 20,
    parameter int T_YELLOW      = 5,
    parameter int CNT_W         = traffic_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             minor_req,
    input  logic             hold,
    output logic [2:0]       major_light,
    output logic [2:0]       minor_light,
    output logic [CNT_W-1:0] major_countdown,
    output logic [CNT_W-1:0] minor_countdown,
    output logic [1:0]       state,
    output logic             phase_change
);

    if (CNT_W != 6 ||
        T_MAJOR_GREEN < 1 || T_MAJOR_GREEN > 58 ||
        T_MINOR_GREEN < 1 || T_MINOR_GREEN > 58 ||
        T_YELLOW < 1 || T_YELLOW > 5 ||
        T_MAJOR_GREEN + T_YELLOW > 63 || T_MINOR_GREEN + T_YELLOW > 63) begin : g_bad_params
        $error("traffic_fsm: phase durations out of range for a %0d-bit countdown", CNT_W);
    end

    localparam logic [CNT_W-1:0] C_MAJ_G = CNT_W'(T_MAJOR_GREEN);
    localparam logic [CNT_W-1:0] C_MIN_G = CNT_W'(T_MINOR_GREEN);
    localparam logic [CNT_W-1:0] C_YEL   = CNT_W'(T_YELLOW);

    phase_e           state_q, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, load_val;
    logic             load, en, expire, armed;

    // armed stays low for the first edge after reset release, so a tick coinciding with it is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) armed <= 1'b0;
        else     armed <= 1'b1;
    end

    assign en = tick_1hz && !hold && armed;

    phase_timer #(.RST_VAL(C_MAJ_G)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .cnt      (cnt),
        .expire   (expire)
    );

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_val = C_MAJ_G;
        if (cnt == '0) begin
            load = 1'b1;
            state_d = MAJ_G;
        end else if (expire) begin
            load = 1'b1;
            unique case (state_q)
                MAJ_G: if (minor_req) begin
                           state_d  = MAJ_Y;
                           load_val = C_YEL;
                       end
                MAJ_Y: begin state_d = MIN_G; load_val = C_MIN_G; end
                MIN_G: begin state_d = MIN_Y; load_val = C_YEL;   end
                MIN_Y: begin state_d = MAJ_G; load_val = C_MAJ_G; end
            endcase
        end
        cnt_d = load ? load_val : (en ? cnt - CNT_W'(1) : cnt);
    end

    logic [2:0]       maj_lamp_d, min_lamp_d;
    logic [CNT_W-1:0] maj_cd_d, min_cd_d;

    // Outputs decode from the next phase/count so they move on the same edge as the state
    always_comb begin
        maj_lamp_d = LAMP_R;
        min_lamp_d = LAMP_R;
        maj_cd_d   = cnt_d;
        min_cd_d   = cnt_d;
        unique case (state_d)
            MAJ_G: begin maj_lamp_d = LAMP_G; min_cd_d = cnt_d + C_YEL; end
            MAJ_Y:       maj_lamp_d = LAMP_Y;
            MIN_G: begin min_lamp_d = LAMP_G; maj_cd_d = cnt_d + C_YEL; end
            MIN_Y:       min_lamp_d = LAMP_Y;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= MAJ_G;
            major_light     <= LAMP_G;
            minor_light     <= LAMP_R;
            major_countdown <= C_MAJ_G;
            minor_countdown <= C_MAJ_G + C_YEL;
            phase_change    <= 1'b0;
        end else begin
            state_q         <= state_d;
            major_light     <= maj_lamp_d;
            minor_light     <= min_lamp_d;
            major_countdown <= maj_cd_d;
            minor_countdown <= min_cd_d;
            phase_change    <= (state_d != state_q);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Bench for traffic_fsm: phase-level reference model compared every cycle, plus directed literal checks.
module tb_traffic_fsm;
    import traffic_pkg::*;

    localparam int T_MG = 4;
    localparam int T_NG = 3;
    localparam int T_Y  = 2;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, minor_req, hold;
    logic [2:0] major_light, minor_light;
    logic [5:0] major_countdown, minor_countdown;
    logic [1:0] state;
    logic       phase_change;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    traffic_fsm #(
        .T_MAJOR_GREEN (T_MG),
        .T_MINOR_GREEN (T_NG),
        .T_YELLOW      (T_Y),
        .CNT_W         (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .tick_1hz        (tick_1hz),
        .minor_req       (minor_req),
        .hold            (hold),
        .major_light     (major_light),
        .minor_light     (minor_light),
        .major_countdown (major_countdown),
        .minor_countdown (minor_countdown),
        .state           (state),
        .phase_change    (phase_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase index plus seconds remaining, stepped once per accepted tick
    int dur[4] = '{T_MG, T_Y, T_NG, T_Y};
    int m_phase = 0;
    int m_rem   = T_MG;
    bit m_armed = 1'b0;
    bit m_pc    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_rem   = T_MG;
            m_armed = 1'b0;
            m_pc    = 1'b0;
        end else begin
            int prev;
            prev = m_phase;
            if (m_armed && tick_1hz && !hold) begin
                if (m_rem > 1)             m_rem--;
                else if (m_phase == 0 && !minor_req) m_rem = T_MG;
                else begin
                    m_phase = (m_phase + 1) % 4;
                    m_rem   = dur[m_phase];
                end
            end
            m_pc    = (m_phase != prev);
            m_armed = 1'b1;
        end
    end

    // Seconds until a road's lamp changes: the other road's green adds its yellow on top
    function automatic int exp_major_cd(int ph, int rem);
        return (ph == 2) ? rem + T_Y : rem;
    endfunction

    function automatic int exp_minor_cd(int ph, int rem);
        return (ph == 0) ? rem + T_Y : rem;
    endfunction

    function automatic int exp_major_lamp(int ph);
        return (ph == 0) ? int'(LAMP_G) : (ph == 1) ? int'(LAMP_Y) : int'(LAMP_R);
    endfunction

    function automatic int exp_minor_lamp(int ph);
        return (ph == 2) ? int'(LAMP_G) : (ph == 3) ? int'(LAMP_Y) : int'(LAMP_R);
    endfunction

    always @(negedge clk) begin
        if (run) begin
            check("cmp_state",     state,           m_phase);
            check("cmp_major_cd",  major_countdown, exp_major_cd(m_phase, m_rem));
            check("cmp_minor_cd",  minor_countdown, exp_minor_cd(m_phase, m_rem));
            check("cmp_major_lmp", major_light,     exp_major_lamp(m_phase));
            check("cmp_minor_lmp", minor_light,     exp_minor_lamp(m_phase));
            check("cmp_phase_chg", phase_change,    m_pc);
            check("one_red_min",   (major_light == LAMP_R) || (minor_light == LAMP_R), 1);
        end
    end

    // Flags a tick that stays high on consecutive edges
    int  tick_viol = 0;
    bit  tick_prev = 1'b0;
    always @(posedge clk) begin
        if (tick_1hz && tick_prev) tick_viol++;
        tick_prev = tick_1hz;
    end

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (9) @(negedge clk);
            tick_1hz = 1'b1;
            @(negedge clk);
            tick_1hz = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; minor_req = 1'b1; hold = 1'b0;
        repeat (3) @(negedge clk);

        // Release with a tick on the very first edge: it must be dropped
        rst = 1'b0; tick_1hz = 1'b1; run = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        check("rst_major_light", major_light, 3'b001);
        check("rst_minor_light", minor_light, 3'b100);
        check("rst_major_cd", major_countdown, 4);
        check("rst_minor_cd", minor_countdown, 6);
        check("rst_state", state, 0);
        check("rst_phase_chg", phase_change, 0);

        // Major green countdown and entry into major yellow
        do_ticks(1); check("t1_major_cd", major_countdown, 3); check("t1_minor_cd", minor_countdown, 5);
        do_ticks(1); check("t2_major_cd", major_countdown, 2); check("t2_minor_cd", minor_countdown, 4);
        do_ticks(1); check("t3_major_cd", major_countdown, 1); check("t3_minor_cd", minor_countdown, 3);
        do_ticks(1);
        check("t4_state", state, 1);
        check("t4_major_light", major_light, 3'b010);
        check("t4_major_cd", major_countdown, 2);
        check("t4_minor_cd", minor_countdown, 2);
        check("t4_pc_pulse", phase_change, 1);
        @(negedge clk);
        check("t4_pc_single", phase_change, 0);

        // Rest of the full cycle
        do_ticks(2);
        check("min_g_state", state, 2);
        check("min_g_minor_cd", minor_countdown, 3);
        check("min_g_major_cd", major_countdown, 5);
        check("min_g_minor_light", minor_light, 3'b001);
        do_ticks(3);
        check("min_y_state", state, 3);
        check("min_y_minor_light", minor_light, 3'b010);
        do_ticks(2);
        check("cycle_state", state, 0);
        check("cycle_major_cd", major_countdown, 4);

        // Rest-on-major when no minor demand at expiry
        minor_req = 1'b0;
        do_ticks(4);
        check("rest_state", state, 0);
        check("rest_major_cd", major_countdown, 4);
        check("rest_minor_cd", minor_countdown, 6);
        check("rest_no_pc", phase_change, 0);
        minor_req = 1'b1;
        do_ticks(3);
        check("rest_still_g", state, 0);
        do_ticks(1);
        check("rest_then_y", state, 1);

        // Hold mid minor green
        do_ticks(2);
        do_ticks(1);
        check("pre_hold_minor_cd", minor_countdown, 2);
        hold = 1'b1;
        do_ticks(5);
        check("hold_minor_cd", minor_countdown, 2);
        check("hold_state", state, 2);
        hold = 1'b0;
        do_ticks(1);
        check("post_hold_minor_cd", minor_countdown, 1);

        // Asynchronous reset mid minor yellow
        do_ticks(1);
        check("pre_rst_state", state, 3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_major_light", major_light, 3'b001);
        check("arst_minor_light", minor_light, 3'b100);
        check("arst_major_cd", major_countdown, 4);
        check("arst_minor_cd", minor_countdown, 6);
        check("arst_state", state, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // A tick held for three clocks counts three times and trips the pulse checker
        tick_1hz = 1'b1;
        repeat (3) @(negedge clk);
        tick_1hz = 1'b0;
        check("long_tick_major_cd", major_countdown, 1);
        check("long_tick_minor_cd", minor_countdown, 3);
        check("long_tick_flagged", tick_viol, 2);

        repeat (5) @(negedge clk);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
